// File: rtl/parking_display_ctrl.sv
// Purpose: parking-lot occupancy counter with a six-digit glyph display (free spots / FULL / CLEAR banner).
// Latency: occupied, full and reject update on the sampling edge; hex0..hex5 lag state/occupied by one cycle.
// Backpressure: none; enter pulses at capacity are refused and flagged on reject for one cycle.
module parking_display_ctrl #(
    parameter int CAPACITY    = 3,
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_enter,
    input  logic       car_exit,
    output logic [4:0] hex0,
    output logic [4:0] hex1,
    output logic [4:0] hex2,
    output logic [4:0] hex3,
    output logic [4:0] hex4,
    output logic [4:0] hex5,
    output logic [6:0] occupied,
    output logic       full,
    output logic       reject
);

    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [6:0]    CAP7     = 7'(CAPACITY);

    // Glyph codes understood by the downstream seven-segment encoder.
    localparam logic [4:0] G_A     = 5'd10;
    localparam logic [4:0] G_C     = 5'd12;
    localparam logic [4:0] G_E     = 5'd14;
    localparam logic [4:0] G_F     = 5'd15;
    localparam logic [4:0] G_L     = 5'd21;
    localparam logic [4:0] G_R     = 5'd27;
    localparam logic [4:0] G_U     = 5'd30;
    localparam logic [4:0] G_BLANK = 5'd31;
    localparam logic [4:0] CAP_TENS = 5'(CAPACITY / 10);
    localparam logic [4:0] CAP_ONES = 5'(CAPACITY % 10);

    typedef enum logic [1:0] {IDLE, PARTIAL, FULL, BANNER} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [6:0]      occ_next;
    logic [6:0]      remaining;
    logic            inc, dec, reject_next;
    logic [5:0][4:0] hex_q, hex_next;

    assign full = (occupied == CAP7);
    assign {hex5, hex4, hex3, hex2, hex1, hex0} = hex_q;

    // Next occupancy, next state / banner countdown, reject flag and display glyphs.
    always_comb begin
        inc         = car_enter && !car_exit && (occupied != CAP7);
        dec         = car_exit && !car_enter && (occupied != 7'd0);
        reject_next = car_enter && !car_exit && (occupied == CAP7);
        occ_next    = occupied;
        state_next  = state;
        cnt_next    = cnt;
        remaining   = CAP7 - occupied;
        hex_next    = {G_BLANK, G_BLANK, G_BLANK, G_BLANK,
                       5'(remaining / 7'd10), 5'(remaining % 7'd10)};

        if (inc) begin
            occ_next = occupied + 7'd1;
        end else if (dec) begin
            occ_next = occupied - 7'd1;
        end

        // Transitions are decided on the post-update count; the last car leaving starts the banner.
        if (dec && (occupied == 7'd1)) begin
            state_next = BANNER;
            cnt_next   = CNT_LOAD;
        end else if (occ_next == CAP7) begin
            state_next = FULL;
            cnt_next   = '0;
        end else if (occ_next != 7'd0) begin
            state_next = PARTIAL;
            cnt_next   = '0;
        end else if ((state == BANNER) && (cnt != '0)) begin
            state_next = BANNER;
            cnt_next   = cnt - 1'b1;
        end else begin
            state_next = IDLE;
            cnt_next   = '0;
        end

        case (state)
            FULL:    hex_next = {G_F, G_U, G_L, G_L, 5'd0, 5'd0};
            BANNER:  hex_next = {G_C, G_L, G_E, G_A, G_R, G_BLANK};
            default: ;
        endcase
    end

    // State, counters and registered display; reset wins over any car event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            occupied <= 7'd0;
            cnt      <= '0;
            reject   <= 1'b0;
            hex_q    <= {G_BLANK, G_BLANK, G_BLANK, G_BLANK, CAP_TENS, CAP_ONES};
        end else begin
            state    <= state_next;
            occupied <= occ_next;
            cnt      <= cnt_next;
            reject   <= reject_next;
            hex_q    <= hex_next;
        end
    end

endmodule

// File: tb/tb_parking_display_ctrl.sv
// Purpose: directed, table-driven check of parking_display_ctrl with CAPACITY=3, HOLD_CYCLES=4.
// Latency: one vector per clock; outputs sampled 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_parking_display_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       car_enter;
    logic       car_exit;
    logic [4:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0] occupied;
    logic       full;
    logic       reject;

    int n_checks = 0;
    int n_fail   = 0;

    parking_display_ctrl #(.CAPACITY(3), .HOLD_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .car_enter(car_enter), .car_exit(car_exit),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .occupied(occupied), .full(full), .reject(reject)
    );

    always #5 clk = ~clk;

    localparam logic [29:0] H_FULL  = {5'd15, 5'd30, 5'd21, 5'd21, 5'd0, 5'd0};
    localparam logic [29:0] H_CLEAR = {5'd12, 5'd21, 5'd14, 5'd10, 5'd27, 5'd31};

    function automatic logic [29:0] h_free(input logic [4:0] t, input logic [4:0] o);
        return {5'd31, 5'd31, 5'd31, 5'd31, t, o};
    endfunction

    typedef struct {
        logic        e;
        logic        x;
        logic [6:0]  occ;
        logic        fl;
        logic        rj;
        logic [29:0] hex;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic e, input logic x, input logic [6:0] occ,
                                input logic fl, input logic rj, input logic [29:0] hex);
        vec_t v;
        v.e = e; v.x = x; v.occ = occ; v.fl = fl; v.rj = rj; v.hex = hex;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // One clock with the given inputs; outputs are left settled for sampling afterwards.
    task automatic cyc(input logic rst, input logic e, input logic x);
        reset = rst; car_enter = e; car_exit = x;
        @(posedge clk);
        #1;
        reset = 1'b0; car_enter = 1'b0; car_exit = 1'b0;
    endtask

    task automatic check_all(input string name, input int idx, input logic [6:0] occ,
                             input logic fl, input logic rj, input logic [29:0] hex);
        check({name, ".occupied"}, idx, 32'(occupied), 32'(occ));
        check({name, ".full"},     idx, 32'(full),     32'(fl));
        check({name, ".reject"},   idx, 32'(reject),   32'(rj));
        check({name, ".hex"},      idx, 32'({hex5, hex4, hex3, hex2, hex1, hex0}), 32'(hex));
    endtask

    initial begin
        // Main walk from empty to full, back to empty, through the whole 4-cycle banner.
        tbl[0]  = mk(0, 0, 0, 0, 0, h_free(0, 3));
        tbl[1]  = mk(0, 1, 0, 0, 0, h_free(0, 3));   // exit while empty ignored
        tbl[2]  = mk(1, 1, 0, 0, 0, h_free(0, 3));   // both at 0
        tbl[3]  = mk(1, 0, 1, 0, 0, h_free(0, 3));
        tbl[4]  = mk(1, 0, 2, 0, 0, h_free(0, 2));
        tbl[5]  = mk(1, 1, 2, 0, 0, h_free(0, 1));   // both at 2
        tbl[6]  = mk(1, 0, 3, 1, 0, h_free(0, 1));
        tbl[7]  = mk(0, 0, 3, 1, 0, H_FULL);
        tbl[8]  = mk(1, 0, 3, 1, 1, H_FULL);         // refused enter
        tbl[9]  = mk(0, 0, 3, 1, 0, H_FULL);         // reject lasts one cycle
        tbl[10] = mk(1, 1, 3, 1, 0, H_FULL);         // both at full
        tbl[11] = mk(0, 1, 2, 0, 0, H_FULL);
        tbl[12] = mk(0, 1, 1, 0, 0, h_free(0, 1));
        tbl[13] = mk(0, 0, 1, 0, 0, h_free(0, 2));
        tbl[14] = mk(0, 1, 0, 0, 0, h_free(0, 2));   // last car out -> banner
        tbl[15] = mk(0, 0, 0, 0, 0, H_CLEAR);
        tbl[16] = mk(0, 0, 0, 0, 0, H_CLEAR);
        tbl[17] = mk(0, 0, 0, 0, 0, H_CLEAR);
        tbl[18] = mk(0, 0, 0, 0, 0, H_CLEAR);
        tbl[19] = mk(0, 0, 0, 0, 0, h_free(0, 3));
        tbl[20] = mk(0, 0, 0, 0, 0, h_free(0, 3));

        reset = 1'b1; car_enter = 1'b0; car_exit = 1'b0;
        @(negedge clk);
        cyc(1, 0, 0);
        check_all("reset", 0, 0, 0, 0, h_free(0, 3));

        for (int i = 0; i < 21; i++) begin
            cyc(0, tbl[i].e, tbl[i].x);
            check_all("table", i, tbl[i].occ, tbl[i].fl, tbl[i].rj, tbl[i].hex);
        end

        // Enter on the second banner cycle aborts the banner.
        cyc(0, 1, 0);
        cyc(0, 0, 1);                                // banner cycle 1 follows
        check_all("abort", 0, 0, 0, 0, h_free(0, 2));
        cyc(0, 0, 0);                                // banner cycle 2 follows
        check_all("abort", 1, 0, 0, 0, H_CLEAR);
        cyc(0, 1, 0);
        check_all("abort", 2, 1, 0, 0, H_CLEAR);
        cyc(0, 0, 0);
        check_all("abort", 3, 1, 0, 0, h_free(0, 2));
        cyc(0, 0, 0);
        check_all("abort", 4, 1, 0, 0, h_free(0, 2));

        // Reset on the second banner cycle, with a simultaneous enter that must lose.
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        check_all("rstban", 0, 0, 0, 0, H_CLEAR);
        cyc(1, 1, 0);
        check_all("rstban", 1, 0, 0, 0, h_free(0, 3));
        for (int i = 2; i < 7; i++) begin
            cyc(0, 0, 0);
            check_all("rstban", i, 0, 0, 0, h_free(0, 3));
        end

        // Exit alone while empty after reset.
        cyc(0, 0, 1);
        check_all("exit0", 0, 0, 0, 0, h_free(0, 3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
